// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants and branch/jump target helper for the fetch unit
package ifu_pkg;
  localparam int ENTRY_W = 64;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J = 6'h02;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  // Jump beats branch when both flags are set.
  function automatic logic [31:0] br_target(input logic j, input logic [31:0] br_pc,
                                            input logic [15:0] imm16, input logic [25:0] tgt26);
    logic [31:0] pc4;
    pc4 = br_pc + 32'd4;
    return j ? {pc4[31:28], tgt26, 2'b00} : pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  endfunction
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: generic DEPTH-entry queue with push, pop, flush and occupancy count
module ifu_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [0:DEPTH-1];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // Flush dominates push/pop; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: PC, instruction ROM and prefetch queue feeding decode.
// Optional perf counters enabled by defining IFU_PERF_EN.
module ifu_fetch_queue import ifu_pkg::*; #(
  parameter int IM_AW = 10,
  parameter int QDEPTH = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_valid,
  input  logic        npc_sel,
  input  logic        zero,
  input  logic        j,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_imm16,
  input  logic [25:0] br_tgt26,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] insout,
  output logic [31:0] pc_out,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
);
  localparam int CW = $clog2(QDEPTH) + 1;
  logic [31:0] im [0:2**IM_AW-1];
  logic [31:0] pc;
  logic [CW-1:0] cnt;
  logic [ENTRY_W-1:0] head;
  logic redir, pop, push;
  assign redir = br_valid & (j | (npc_sel & zero));
  assign pop = if_valid & id_ready;
  assign push = !redir & ((cnt != CW'(QDEPTH)) | pop);
  assign if_valid = cnt != '0;
  ifu_fifo #(.DEPTH(QDEPTH), .W(ENTRY_W)) u_fifo (
    .clk(clk), .reset(reset), .flush(redir), .push(push), .pop(pop),
    .din({pc, im[pc[IM_AW+1:2]]}), .dout(head), .count(cnt)
  );
  always_ff @(posedge clk) begin
    if (!reset) pc <= RESET_PC;
    else if (redir) pc <= br_target(j, br_pc, br_imm16, br_tgt26);
    else if (push) pc <= pc + 32'd4;
  end
  assign pc_out = head[63:32];
  assign insout = head[31:0];
  assign opcode = insout[OPC_MSB:OPC_LSB];
  assign rs = insout[RS_MSB:RS_LSB];
  assign rt = insout[RT_MSB:RT_LSB];
  assign rd = insout[RD_MSB:RD_LSB];
  assign funct = insout[FN_MSB:FN_LSB];
  assign imm16 = insout[IMM_MSB:IMM_LSB];
`ifdef IFU_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + {31'd0, push};
      flush_cnt <= flush_cnt + {31'd0, redir};
    end
  end
`else
  assign fetch_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb_ifu_fetch_queue: scoreboard bench for the fetch queue (with or without IFU_PERF_EN)
module tb_ifu_fetch_queue;
  logic clk = 0;
  logic reset, br_valid, npc_sel, zero, j, id_ready;
  logic [31:0] br_pc;
  logic [15:0] br_imm16;
  logic [25:0] br_tgt26;
  logic if_valid;
  logic [31:0] insout, pc_out, fetch_cnt, flush_cnt;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm16;
  logic must_valid;
  int checks = 0, failures = 0;
  logic [31:0] exp_q [$];

  ifu_fetch_queue dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .npc_sel(npc_sel), .zero(zero), .j(j),
    .br_pc(br_pc), .br_imm16(br_imm16), .br_tgt26(br_tgt26), .id_ready(id_ready),
    .if_valid(if_valid), .insout(insout), .pc_out(pc_out), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .funct(funct), .imm16(imm16), .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rom_of(input logic [31:0] a);
    return 32'h3C01_0001 + {22'd0, a[11:2]};
  endfunction

  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 64; k++) exp_q.push_back(start + 32'(4 * k));
  endtask

  // Called at negedge with the next edge's inputs already driven.
  task automatic cyc();
    logic [31:0] e;
    if (reset && if_valid && id_ready && !(br_valid && (j || (npc_sel && zero)))) begin
      if (exp_q.size() == 0) check("sb_empty", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("pc", pc_out, e);
        check("ins", insout, rom_of(e));
      end
    end
    if (must_valid) check("no_gap", if_valid, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 5 && !if_valid; n++) cyc();
    check("wait_valid", if_valid, 1);
  endtask

  initial begin
    reset = 0; br_valid = 0; npc_sel = 0; zero = 0; j = 0; id_ready = 1;
    br_pc = 0; br_imm16 = 0; br_tgt26 = 0; must_valid = 0;
    for (int i = 0; i < 1024; i++) dut.im[i] = 32'h3C01_0001 + 32'(i);
    @(negedge clk);
    cyc();
    cyc();
    check("rst_valid", if_valid, 0);
    check("rst_fetch_cnt", fetch_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    // 1: reset release, one-cycle latency
    reset = 1;
    restart_stream(32'h0);
    cyc();
    check("lat_valid", if_valid, 1);
    check("lat_pc", pc_out, 0);
    check("opcode", opcode, 6'h0F);
    check("rt", rt, 5'd1);
    for (int k = 0; k < 4; k++) cyc();
    // 2: stall fills the queue, then drains without gaps
    id_ready = 0;
    for (int k = 0; k < 10; k++) cyc();
    check("stall_valid", if_valid, 1);
    check("stall_pc", pc_out, exp_q[0]);
    id_ready = 1;
    must_valid = 1;
    for (int k = 0; k < 8; k++) cyc();
    must_valid = 0;
`ifdef IFU_PERF_EN
    check("fetch_cnt_nz", fetch_cnt != 0, 1);
`else
    check("fetch_cnt_off", fetch_cnt, 0);
`endif
    // 3: taken beq back to 4
    br_valid = 1; npc_sel = 1; zero = 1; br_pc = 32'h8; br_imm16 = 16'hFFFE;
    cyc();
    br_valid = 0; npc_sel = 0; zero = 0;
    restart_stream(32'h4);
    check("flush_valid", if_valid, 0);
`ifdef IFU_PERF_EN
    check("flush_cnt1", flush_cnt, 1);
`else
    check("flush_cnt_off", flush_cnt, 0);
`endif
    wait_valid();
    check("beq_pc", pc_out, 32'h4);
    for (int k = 0; k < 4; k++) cyc();
    // 4: jump, j wins over npc_sel
    br_valid = 1; j = 1; npc_sel = 1; zero = 1; br_pc = 32'h10; br_tgt26 = 26'h40;
    cyc();
    br_valid = 0; j = 0; npc_sel = 0; zero = 0;
    restart_stream(32'h100);
    check("jflush_valid", if_valid, 0);
    wait_valid();
    check("j_pc", pc_out, 32'h100);
`ifdef IFU_PERF_EN
    check("flush_cnt2", flush_cnt, 2);
`endif
    for (int k = 0; k < 4; k++) cyc();
    // 5: not-taken branch leaves stream intact
    must_valid = 1;
    br_valid = 1; npc_sel = 1; zero = 0; br_pc = 32'h104; br_imm16 = 16'h0040;
    cyc();
    br_valid = 0; npc_sel = 0;
    for (int k = 0; k < 4; k++) cyc();
    must_valid = 0;
    // 6: reset overrides redirect on a full queue
    id_ready = 0;
    for (int k = 0; k < 6; k++) cyc();
    check("full_valid", if_valid, 1);
    reset = 0; br_valid = 1; j = 1; br_pc = 32'h40; br_tgt26 = 26'h80;
    cyc();
    br_valid = 0; j = 0;
    check("rst6_valid", if_valid, 0);
    check("rst6_fetch_cnt", fetch_cnt, 0);
    check("rst6_flush_cnt", flush_cnt, 0);
    reset = 1; id_ready = 1;
    restart_stream(32'h0);
    cyc();
    check("rst6_lat_valid", if_valid, 1);
    check("rst6_pc", pc_out, 32'h0);
    for (int k = 0; k < 5; k++) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
